// File: rtl/mips_multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
//   Bundle between the multi-cycle MIPS control FSM and its datapath.
//   master : the controller (consumes IR fields, ALU zero and the memory
//            handshake; drives ALU command, operand selects and strobes)
//   slave  : the datapath / memory side
//
//   opcode, funct   IR[31:26], IR[5:0]
//   zero            ALU ZERO flag
//   mem_ready       memory access completes when high during a request
//   alu_op          ALU command
//   alu_src_a       0=PC, 1=reg A
//   alu_src_b       00=reg B, 01=4, 10=sext(imm), 11=sext(imm)<<2
//   pc_src          00=ALU result, 01=ALUOut, 10=jump target
//   pc_write, ir_write, iord, mem_read, mem_write,
//   reg_write, reg_dst, mem_to_reg   datapath strobes / selects
//   illegal         one-cycle pulse on an unsupported opcode or funct
//   state           current FSM state, for debug
// ----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write,
               iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
               illegal, state
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write,
               iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
               illegal, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multi-cycle MIPS main control FSM. Issues one ALU command per cycle and
//   sequences PC, IR, memory and register-file strobes from the decoded IR.
//
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mips_multicycle_ctrl_if.master (IR fields, zero, mem_ready in;
//          ALU command, selects, strobes, illegal and debug state out)
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   RST  15 | reset value, all strobes low, advances to FETCH
//   FETCH 0 | read instruction at PC, PC+4; waits for mem_ready
//   DECODE 1| branch target precompute, dispatch on opcode
//   MEMADR 2| lw/sw address = A + sext(imm)
//   MEMRD 3 | data read at ALUOut; waits for mem_ready
//   MEMWB 4 | write MDR to rt
//   MEMWR 5 | data write at ALUOut; waits for mem_ready
//   EXEC  6 | R-type ALU operation on A, B
//   ALUWB 7 | write ALUOut to rd
//   BRANCH 8| beq compare, PC <= ALUOut when equal
//   ADDIEX 9| A + sext(imm)
//   ADDIWB10| write ALUOut to rt
//   JUMP 11 | PC <= jump target
// ----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter logic [3:0] OP_AND = 4'b0000,
    parameter logic [3:0] OP_OR  = 4'b0001,
    parameter logic [3:0] OP_ADD = 4'b0010,
    parameter logic [3:0] OP_SUB = 4'b0110,
    parameter logic [3:0] OP_SLT = 4'b0111,
    parameter logic [3:0] OP_NOR = 4'b1100,
    parameter logic [3:0] OP_EQ  = 4'b0101
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_RST    = 4'd15
    } state_t;

    state_t     state_q;
    state_t     state_d;

    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = S_FETCH;
        alu_op     = OP_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_RST: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                // IR and PC+4 are captured only on the completing beat
                ir_write  = bus.mem_ready;
                pc_write  = bus.mem_ready;
                state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (bus.opcode)
                    OPC_RTYPE:      state_d = S_EXEC;
                    OPC_LW, OPC_SW: state_d = S_MEMADR;
                    OPC_BEQ:        state_d = S_BRANCH;
                    OPC_ADDI:       state_d = S_ADDIEX;
                    OPC_J:          state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (bus.funct)
                    6'b100000: alu_op = OP_ADD;
                    6'b100010: alu_op = OP_SUB;
                    6'b100100: alu_op = OP_AND;
                    6'b100101: alu_op = OP_OR;
                    6'b101010: alu_op = OP_SLT;
                    6'b100111: alu_op = OP_NOR;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (bus.opcode == OPC_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                state_d  = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = OP_EQ;
                pc_src    = 2'b01;
                pc_write  = bus.zero;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                // encodings 12-14 are unreachable; recover without strobes
                illegal = 1'b1;
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.alu_op     = alu_op;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.pc_src     = pc_src;
    assign bus.pc_write   = pc_write;
    assign bus.ir_write   = ir_write;
    assign bus.iord       = iord;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.illegal    = illegal;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic clk;
    logic rst_n;
    int   ntests;
    int   nfail;

    mips_multicycle_ctrl_if bus();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] aop;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pcw;
        logic       irw;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
    } outv_t;

    typedef struct {
        outv_t exp;
        logic  rdy;
        logic  z;
    } cyc_t;

    cyc_t exp_q[$];

    localparam logic [5:0] RT = 6'h00, LW = 6'h23, SW = 6'h2B, BQ = 6'h04, AI = 6'h08, JJ = 6'h02;

    function automatic outv_t observed();
        outv_t o;
        o = {bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_src,
             bus.pc_write, bus.ir_write, bus.iord, bus.mem_read, bus.mem_write,
             bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.illegal};
        return o;
    endfunction

    function automatic outv_t blank(input logic [3:0] st);
        outv_t e;
        e     = '0;
        e.st  = st;
        e.aop = 4'b0010;
        return e;
    endfunction

    function automatic logic legal_op(input logic [5:0] op);
        return (op == RT) || (op == LW) || (op == SW) || (op == BQ) || (op == AI) || (op == JJ);
    endfunction

    // {valid, alu command} for an R-type funct
    function automatic logic [4:0] rtype_cmd(input logic [5:0] fn);
        case (fn)
            6'h20:   return {1'b1, 4'b0010};
            6'h22:   return {1'b1, 4'b0110};
            6'h24:   return {1'b1, 4'b0000};
            6'h25:   return {1'b1, 4'b0001};
            6'h2A:   return {1'b1, 4'b0111};
            6'h27:   return {1'b1, 4'b1100};
            default: return 5'b0;
        endcase
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input outv_t e, input logic rdy, input logic z);
        cyc_t c;
        c.exp = e;
        c.rdy = rdy;
        c.z   = z;
        exp_q.push_back(c);
    endtask

    // Expected per-cycle outputs for one instruction, from the instruction's class
    task automatic build(input logic [5:0] op, input logic [5:0] fn,
                         input int wf, input int wm, input logic z);
        outv_t     e;
        logic [4:0] rc;
        exp_q.delete();
        for (int i = 0; i < wf; i++) begin
            e = blank(4'd0); e.mr = 1'b1; e.sb = 2'b01;
            push(e, 1'b0, rbit());
        end
        e = blank(4'd0); e.mr = 1'b1; e.sb = 2'b01; e.irw = 1'b1; e.pcw = 1'b1;
        push(e, 1'b1, rbit());
        e = blank(4'd1); e.sb = 2'b11;
        if (!legal_op(op)) begin
            e.ill = 1'b1;
            push(e, rbit(), rbit());
            return;
        end
        push(e, rbit(), rbit());
        case (op)
            RT: begin
                rc = rtype_cmd(fn);
                e = blank(4'd6); e.sa = 1'b1;
                if (rc[4]) begin
                    e.aop = rc[3:0];
                    push(e, rbit(), rbit());
                    e = blank(4'd7); e.rw = 1'b1; e.rd = 1'b1;
                    push(e, rbit(), rbit());
                end else begin
                    e.ill = 1'b1;
                    push(e, rbit(), rbit());
                end
            end
            LW, SW: begin
                e = blank(4'd2); e.sa = 1'b1; e.sb = 2'b10;
                push(e, rbit(), rbit());
                e = blank((op == LW) ? 4'd3 : 4'd5); e.iord = 1'b1;
                if (op == LW) e.mr = 1'b1; else e.mw = 1'b1;
                for (int i = 0; i < wm; i++) push(e, 1'b0, rbit());
                push(e, 1'b1, rbit());
                if (op == LW) begin
                    e = blank(4'd4); e.rw = 1'b1; e.m2r = 1'b1;
                    push(e, rbit(), rbit());
                end
            end
            BQ: begin
                e = blank(4'd8); e.sa = 1'b1; e.aop = 4'b0101; e.ps = 2'b01; e.pcw = z;
                push(e, rbit(), z);
            end
            AI: begin
                e = blank(4'd9); e.sa = 1'b1; e.sb = 2'b10;
                push(e, rbit(), rbit());
                e = blank(4'd10); e.rw = 1'b1;
                push(e, rbit(), rbit());
            end
            default: begin
                e = blank(4'd11); e.ps = 2'b10; e.pcw = 1'b1;
                push(e, rbit(), rbit());
            end
        endcase
    endtask

    // Starts at a negedge with the DUT in FETCH; ends at the negedge of the next FETCH
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int wf, input int wm, input logic z);
        outv_t got;
        build(op, fn, wf, wm, z);
        bus.opcode = op;
        bus.funct  = fn;
        for (int i = 0; i < exp_q.size(); i++) begin
            bus.mem_ready = exp_q[i].rdy;
            bus.zero      = exp_q[i].z;
            #1;
            got = observed();
            ntests++;
            if (got !== exp_q[i].exp) begin
                nfail++;
                $display("FAIL %s op=%h fn=%h cyc%0d: got %h required %h",
                         name, op, fn, i, got, exp_q[i].exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_now(input string name, input outv_t want);
        outv_t got;
        got = observed();
        ntests++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        outv_t e;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        bus.opcode = JJ;
        bus.funct = 6'h00;
        repeat (2) @(negedge clk);
        #1 check_now("reset_held", blank(4'd15));
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'b0;
        #1 check_now("reset_release", blank(4'd15));
        @(negedge clk);
        e = blank(4'd0); e.mr = 1'b1; e.sb = 2'b01;
        #1 check_now("first_fetch", e);
    endtask

    task automatic test_rtype();
        logic [5:0] fns [6];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        for (int i = 0; i < 6; i++) run_instr("rtype", RT, fns[i], 0, 0, 1'b0);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait", LW, 6'h15, 3, 3, 1'b0);
        run_instr("sw_wait", SW, 6'h00, 2, 3, 1'b1);
    endtask

    task automatic test_beq();
        run_instr("beq_taken", BQ, 6'h3C, 0, 0, 1'b1);
        run_instr("beq_not_taken", BQ, 6'h3C, 0, 0, 1'b0);
    endtask

    task automatic test_illegal();
        run_instr("illegal_opcode", 6'h3F, 6'h20, 0, 0, 1'b0);
        run_instr("illegal_funct", RT, 6'h01, 0, 0, 1'b0);
        run_instr("after_illegal", AI, 6'h00, 1, 0, 1'b0);
    endtask

    task automatic test_latency();
        logic [5:0] ops [5];
        int         lat [5];
        int         n;
        ops = '{RT, LW, SW, BQ, JJ};
        lat = '{4, 5, 4, 3, 3};
        for (int i = 0; i < 5; i++) begin
            bus.opcode    = ops[i];
            bus.funct     = 6'h20;
            bus.mem_ready = 1'b1;
            n = 0;
            do begin
                n++;
                @(negedge clk);
            end while (bus.state !== 4'd0 && n < 20);
            ntests++;
            if (n != lat[i]) begin
                nfail++;
                $display("FAIL latency op=%h: got %0d cycles required %0d", ops[i], n, lat[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        logic [5:0] fns [6];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{RT, LW, SW, BQ, AI, JJ};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else op = ops[$urandom_range(0, 5)];
            if ($urandom_range(0, 5) == 0) fn = 6'($urandom);
            else fn = fns[$urandom_range(0, 5)];
            run_instr("random", op, fn, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end
    endtask

    task automatic test_reset_mid_access();
        outv_t e;
        int    n;
        bus.opcode    = SW;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        n = 0;
        while (bus.state !== 4'd5 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        ntests++;
        if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
            nfail++;
            $display("FAIL reach_memwr: got state %0d mem_write %b required 5 1", bus.state, bus.mem_write);
        end
        #1 rst_n = 1'b0;
        #1 check_now("async_reset_memwr", blank(4'd15));
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_now("reset_mid_release", blank(4'd15));
        @(negedge clk);
        e = blank(4'd0); e.mr = 1'b1; e.sb = 2'b01;
        #1 check_now("fetch_after_mid_reset", e);
    endtask

    initial begin
        ntests = 0;
        nfail  = 0;
        rst_n  = 1'b0;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_illegal();
        test_latency();
        test_random();
        test_reset_mid_access();
        run_instr("post_reset_addi", AI, 6'h00, 0, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
